bk_burst_accumulator: RTL and testbench
=======================================

// Module: bk_burst_accumulator
// PURPOSE
//  Sequential stage wrapped around the team's combinational Brent-Kung adder (Brent).
//  - Sums a burst of N-bit operands delivered on a valid/ready stream.
//  - Feeds a registered running sum back as operand A, the new beat as B, with Cin=0.
//  - Consumes the adder's {carry,sum} output each beat.
//  - Presents the final sum, beat count and overflow flag on an output valid/ready stream.
// PARAMETERS
//  N      32  operand/sum width; must equal the adder's N
//  CNT_W  8   beat-counter width
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      reset: synchronous, active-high
//  in_valid   in   1      input beat valid
//  in_ready   out  1      stage can accept a beat
//  in_data    in   N      operand beat
//  in_last    in   1      marks final beat of burst; qualified by in_valid&in_ready
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  N      burst sum (low N bits; clamped when BK_ACC_SAT_EN)
//  out_count  out  CNT_W  beats in burst, saturating at 2^CNT_W-1
//  out_ovf    out  1      sticky: any beat of the burst produced adder carry-out
// BEHAVIOUR
//  States: IDLE (no burst open), ACC (burst open), OUT (result held).
//  Handshake:
//   - beat accepted iff in_valid & in_ready.
//   - in_ready = (state!=OUT) & !rst.
//   - result consumed iff out_valid & out_ready.
//  Adder inputs: A = (state==IDLE) ? 0 : acc; B = in_data; Cin = 0.
//   - Sum[N-1:0] is the next acc; Sum[N] is the carry.
//  On accept:
//   - acc <= Sum[N-1:0].
//   - cnt <= (IDLE ? 1 : cnt+1); cnt holds at 2^CNT_W-1, no wrap.
//   - ovf <= (IDLE ? 0 : ovf) | Sum[N].
//  Transitions:
//   - IDLE/ACC, accept with !in_last -> ACC.
//   - IDLE/ACC, accept with in_last -> OUT. Same edge loads out_sum/out_count/out_ovf
//     with the post-update values; out_valid=1 the next cycle (1-cycle latency).
//   - OUT & out_ready -> IDLE; out_valid drops the next cycle.
//   - No same-cycle bypass: a new beat cannot be accepted in the cycle the result
//     is consumed.
//   - OUT: out_* stay stable until consumed, regardless of in_* activity.
//   - in_valid without in_ready: ignored, no state change.
//  Single-beat burst (IDLE, in_last on first beat): out_sum=in_data, out_count=1, out_ovf=0.
//  Reset (synchronous, any state, including mid-burst or mid-OUT):
//   - state=IDLE; acc, cnt, ovf = 0.
//   - out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=0 while rst=1.
//   - Any partial burst is discarded.
//  Arithmetic: unsigned modulo 2^N unless BK_ACC_SAT_EN is defined.
// CONFIGURATION
//  Macro: BK_ACC_SAT_EN
//  Defined:
//   - On any accept with Sum[N]=1, acc <= {N{1'b1}}.
//   - Once saturated, acc remains all-ones for the rest of the burst.
//   - out_ovf is set as normal.
//  Not defined:
//   - acc wraps modulo 2^N; only out_ovf records the carry.
//   - No saturation logic is synthesised.
// TESTING
//  1. Burst 3,5,7(last), out_ready=1 -> out_sum=15, out_count=3, out_ovf=0;
//     out_valid exactly 1 cycle after last accept.
//  2. Burst FFFF_FFFF, 2(last) -> out_ovf=1, out_count=2;
//     out_sum=1 (no macro) or FFFF_FFFF (BK_ACC_SAT_EN).
//  3. Single beat 0xDEAD_BEEF with in_last -> out_sum=DEADBEEF, out_count=1, out_ovf=0.
//  4. Result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0,
//     out_* stable; next burst starts from acc=0 after consume.
//  5. rst pulsed after 2 beats of a burst -> all outputs 0;
//     next burst 4(last) gives out_sum=4, out_count=1.
//  6. CNT_W=2, burst of 5 beats of 1 -> out_count=3 (saturated), out_sum=5.

Source files
------------

// File: rtl/bk_burst_accumulator.sv
// bk_burst_accumulator: sums a valid/ready burst of N-bit beats through a
// Brent-Kung adder and presents {sum, beat count, overflow} on an output
// valid/ready stream.
// Optional feature macro: BK_ACC_SAT_EN. When it is defined, the running sum
// clamps to all-ones on adder carry-out. When it is undefined, the sum wraps
// modulo 2^N.

// Combinational Brent-Kung adder: sum = {carry_out, a + b + cin}
module bk_brent_adder #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N:0]   sum
);

  localparam int unsigned DTOP = 1 << $clog2(N);

  logic [N-1:0] p;
  logic [N-1:0] gt;
  logic [N-1:0] pt;

  // Prefix tree: an up-sweep of generate/propagate pairs, then a down-sweep
  // that fills in the intermediate carries.
  always_comb begin
    p     = a ^ b;
    gt    = a & b;
    pt    = p;
    gt[0] = gt[0] | (p[0] & cin);
    for (int unsigned d = 1; d < N; d = d * 2) begin
      for (int unsigned i = 2 * d - 1; i < N; i = i + 2 * d) begin
        gt[i] = gt[i] | (pt[i] & gt[i-d]);
        pt[i] = pt[i] & pt[i-d];
      end
    end
    for (int unsigned d = DTOP; d >= 1; d = d / 2) begin
      for (int unsigned i = 3 * d - 1; i < N; i = i + 2 * d) begin
        gt[i] = gt[i] | (pt[i] & gt[i-d]);
        pt[i] = pt[i] & pt[i-d];
      end
    end
    sum[0] = p[0] ^ cin;
    for (int unsigned i = 1; i < N; i++) begin
      sum[i] = p[i] ^ gt[i-1];
    end
    sum[N] = gt[N-1];
  end

endmodule

module bk_burst_accumulator #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       acc;
  logic [N-1:0]       op_a;
  logic [N-1:0]       acc_upd;
  logic [N:0]         add_sum;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_upd;
  logic               ovf;
  logic               ovf_upd;
  logic               accept;
  logic               consume;

  assign in_ready  = (state != OUT) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign consume   = out_valid && out_ready;
  assign op_a      = (state == IDLE) ? '0 : acc;

  bk_brent_adder #(.N(N)) u_adder (
    .a   (op_a),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Post-accept values of the running sum, beat counter and sticky overflow
  always_comb begin
`ifdef BK_ACC_SAT_EN
    // A saturated acc stays all-ones: any non-zero beat carries out again.
    acc_upd = add_sum[N] ? '1 : add_sum[N-1:0];
`else
    acc_upd = add_sum[N-1:0];
`endif
    if (state == IDLE) begin
      cnt_upd = CNT_W'(1);
    end else if (&cnt) begin
      cnt_upd = cnt;
    end else begin
      cnt_upd = cnt + 1'b1;
    end
    ovf_upd = ((state == IDLE) ? 1'b0 : ovf) | add_sum[N];
  end

  // Next-state logic for the burst FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_next = in_last ? OUT : ACC;
        end
      end
      OUT: begin
        if (consume) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc <= acc_upd;
      cnt <= cnt_upd;
      ovf <= ovf_upd;
      if (in_last) begin
        out_sum   <= acc_upd;
        out_count <= cnt_upd;
        out_ovf   <= ovf_upd;
      end
    end
  end

endmodule

// File: tb/tb_bk_burst_accumulator.sv
// Testbench for bk_burst_accumulator: one instance at the default widths, and
// a second instance with CNT_W=2 for beat-counter saturation.
module tb_bk_burst_accumulator;

  localparam int unsigned N = 32;

  typedef struct {
    logic [N-1:0] sum;
    logic [7:0]   count;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]   v_in_valid;
  logic [1:0]   v_in_last;
  logic [1:0]   v_out_ready;
  logic [N-1:0] v_in_data [2];

  logic         in_ready, out_valid, out_ovf;
  logic [N-1:0] out_sum;
  logic [7:0]   out_count;
  logic         in_ready2, out_valid2, out_ovf2;
  logic [N-1:0] out_sum2;
  logic [1:0]   out_count2;

  int passed = 0;
  int total  = 0;

  // Bench-side model, one set per instance
  logic [N-1:0] m_acc [2];
  int unsigned  m_cnt [2];
  logic         m_ovf [2];
  bit           m_open [2];
  res_t         q [2][$];

  always #5 clk = ~clk;

  bk_burst_accumulator #(.N(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(v_in_valid[0]), .in_ready(in_ready), .in_data(v_in_data[0]), .in_last(v_in_last[0]),
    .out_valid(out_valid), .out_ready(v_out_ready[0]),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  bk_burst_accumulator #(.N(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(v_in_valid[1]), .in_ready(in_ready2), .in_data(v_in_data[1]), .in_last(v_in_last[1]),
    .out_valid(out_valid2), .out_ready(v_out_ready[1]),
    .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  function automatic logic get_ready(input int s);
    return (s == 0) ? in_ready : in_ready2;
  endfunction

  function automatic logic get_valid(input int s);
    return (s == 0) ? out_valid : out_valid2;
  endfunction

  function automatic res_t get_out(input int s);
    res_t r;
    r.sum   = (s == 0) ? out_sum : out_sum2;
    r.count = (s == 0) ? out_count : {6'd0, out_count2};
    r.ovf   = (s == 0) ? out_ovf : out_ovf2;
    return r;
  endfunction

  // Advances the model for one accepted beat; pushes the expected result on last
  task automatic model_beat(input int s, input logic [N-1:0] d, input logic last, input int unsigned cmax);
    logic [N:0] full;
    res_t e;
    full = {1'b0, (m_open[s] ? m_acc[s] : '0)} + {1'b0, d};
`ifdef BK_ACC_SAT_EN
    m_acc[s] = full[N] ? {N{1'b1}} : full[N-1:0];
`else
    m_acc[s] = full[N-1:0];
`endif
    m_cnt[s] = !m_open[s] ? 1 : ((m_cnt[s] < cmax) ? m_cnt[s] + 1 : cmax);
    m_ovf[s] = (m_open[s] ? m_ovf[s] : 1'b0) | full[N];
    m_open[s] = !last;
    if (last) begin
      e.sum = m_acc[s]; e.count = 8'(m_cnt[s]); e.ovf = m_ovf[s];
      q[s].push_back(e);
    end
  endtask

  // Drives one beat (bounded wait for in_ready); returns with the accept edge just passed (+#1)
  task automatic send_beat(input int s, input logic [N-1:0] d, input logic last, output bit timeout);
    int t = 0;
    @(negedge clk);
    v_in_valid[s] = 1'b1; v_in_data[s] = d; v_in_last[s] = last;
    while (!get_ready(s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    timeout = (t >= 50);
    @(posedge clk);
    #1;
    v_in_valid[s] = 1'b0; v_in_last[s] = 1'b0;
    if (!timeout) model_beat(s, d, last, (s == 0) ? 255 : 3);
  endtask

  task automatic wait_valid(input int s, output bit timeout);
    int t = 0;
    while (!get_valid(s) && t < 50) begin
      @(negedge clk);
      t++;
    end
    timeout = (t >= 50);
  endtask

  task automatic consume(input int s);
    @(negedge clk);
    v_out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    v_out_ready[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, required all 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic_burst;
    bit to;
    res_t e, o;
    v_out_ready[0] = 1'b1;
    send_beat(0, 32'd3, 1'b0, to);
    send_beat(0, 32'd5, 1'b0, to);
    total++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b, required 0", out_valid);
    else passed++;
    send_beat(0, 32'd7, 1'b1, to);
    total++;
    if (to || out_valid !== 1'b1) $display("FAIL basic_latency: out_valid got %b (timeout=%0d), required 1", out_valid, to);
    else passed++;
    e = q[0].pop_front();
    o = get_out(0);
    total++;
    if (o.sum !== e.sum || o.count !== e.count || o.ovf !== e.ovf || e.sum !== 32'd15)
      $display("FAIL basic_result: got sum=%0d cnt=%0d ovf=%b, required sum=%0d cnt=%0d ovf=%b (15/3/0)",
               o.sum, o.count, o.ovf, e.sum, e.count, e.ovf);
    else passed++;
    @(posedge clk);
    #1;
    v_out_ready[0] = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL basic_consumed: out_valid got %b, required 0", out_valid);
    else passed++;
  endtask

  task automatic test_overflow;
    bit to;
    res_t e, o;
    send_beat(0, 32'hFFFF_FFFF, 1'b0, to);
    send_beat(0, 32'd2, 1'b1, to);
    wait_valid(0, to);
    e = q[0].pop_front();
    o = get_out(0);
    total++;
`ifdef BK_ACC_SAT_EN
    if (to || o.sum !== 32'hFFFF_FFFF || o.sum !== e.sum)
`else
    if (to || o.sum !== 32'd1 || o.sum !== e.sum)
`endif
      $display("FAIL ovf_sum: got %h (timeout=%0d), required %h", o.sum, to, e.sum);
    else passed++;
    total++;
    if (o.count !== 8'd2 || o.ovf !== 1'b1)
      $display("FAIL ovf_flags: got cnt=%0d ovf=%b, required cnt=2 ovf=1", o.count, o.ovf);
    else passed++;
    consume(0);
    // Sticky overflow: carry on the 2nd beat, none on the 3rd
    send_beat(0, 32'hFFFF_FFFF, 1'b0, to);
    send_beat(0, 32'd1, 1'b0, to);
    send_beat(0, 32'd5, 1'b1, to);
    wait_valid(0, to);
    e = q[0].pop_front();
    o = get_out(0);
    total++;
    if (to || o.sum !== e.sum || o.count !== e.count || o.ovf !== 1'b1 || e.ovf !== 1'b1)
      $display("FAIL ovf_sticky: got sum=%h cnt=%0d ovf=%b, required sum=%h cnt=%0d ovf=1",
               o.sum, o.count, o.ovf, e.sum, e.count);
    else passed++;
    consume(0);
  endtask

  task automatic test_single_beat;
    bit to;
    res_t e, o;
    send_beat(0, 32'hDEAD_BEEF, 1'b1, to);
    wait_valid(0, to);
    e = q[0].pop_front();
    o = get_out(0);
    total++;
    if (to || o.sum !== 32'hDEAD_BEEF || o.count !== 8'd1 || o.ovf !== 1'b0 || o.sum !== e.sum)
      $display("FAIL single_beat: got sum=%h cnt=%0d ovf=%b, required sum=deadbeef cnt=1 ovf=0",
               o.sum, o.count, o.ovf);
    else passed++;
    consume(0);
  endtask

  task automatic test_back_to_back;
    bit to;
    res_t e, o, held;
    send_beat(0, 32'd10, 1'b0, to);
    send_beat(0, 32'd20, 1'b1, to);
    wait_valid(0, to);
    held = get_out(0);
    @(negedge clk);
    v_in_valid[0] = 1'b1; v_in_data[0] = 32'd99; v_in_last[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = get_out(0);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || o.sum !== held.sum || o.count !== held.count || o.ovf !== held.ovf)
        $display("FAIL hold_cycle%0d: got rdy=%b vld=%b sum=%0d cnt=%0d, required rdy=0 vld=1 sum=%0d cnt=%0d",
                 i, in_ready, out_valid, o.sum, o.count, held.sum, held.count);
      else passed++;
    end
    e = q[0].pop_front();
    total++;
    if (held.sum !== e.sum || held.count !== e.count || held.ovf !== e.ovf)
      $display("FAIL hold_result: got sum=%0d cnt=%0d, required sum=%0d cnt=%0d", held.sum, held.count, e.sum, e.count);
    else passed++;
    // Consume with in_valid still high: the beat must not be taken on the same edge
    v_out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    v_out_ready[0] = 1'b0; v_in_valid[0] = 1'b0; v_in_last[0] = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL no_bypass: got vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    else passed++;
    send_beat(0, 32'd6, 1'b1, to);
    wait_valid(0, to);
    e = q[0].pop_front();
    o = get_out(0);
    total++;
    if (to || o.sum !== 32'd6 || o.count !== 8'd1 || o.sum !== e.sum)
      $display("FAIL fresh_burst: got sum=%0d cnt=%0d, required sum=6 cnt=1", o.sum, o.count);
    else passed++;
    consume(0);
  endtask

  task automatic test_reset_mid;
    bit to;
    res_t e, o;
    send_beat(0, 32'd1, 1'b0, to);
    send_beat(0, 32'd2, 1'b0, to);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_open[0] = 0;
    total++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== '0)
      $display("FAIL reset_mid_burst: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, required all 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    else passed++;
    rst = 1'b0;
    send_beat(0, 32'd4, 1'b1, to);
    wait_valid(0, to);
    e = q[0].pop_front();
    o = get_out(0);
    total++;
    if (to || o.sum !== 32'd4 || o.count !== 8'd1 || o.ovf !== 1'b0 || o.sum !== e.sum)
      $display("FAIL after_reset_burst: got sum=%0d cnt=%0d ovf=%b, required sum=4 cnt=1 ovf=0", o.sum, o.count, o.ovf);
    else passed++;
    // Reset while a result is pending clears it
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0)
      $display("FAIL reset_mid_out: got vld=%b sum=%0d cnt=%0d, required 0/0/0", out_valid, out_sum, out_count);
    else passed++;
  endtask

  task automatic test_count_saturation;
    bit to;
    res_t e, o;
    for (int i = 0; i < 5; i++) begin
      send_beat(1, 32'd1, (i == 4), to);
    end
    wait_valid(1, to);
    e = q[1].pop_front();
    o = get_out(1);
    total++;
    if (to || o.count !== 8'd3 || o.sum !== 32'd5 || o.ovf !== 1'b0 || o.count !== e.count || o.sum !== e.sum)
      $display("FAIL count_saturation: got sum=%0d cnt=%0d ovf=%b, required sum=5 cnt=3 ovf=0", o.sum, o.count, o.ovf);
    else passed++;
    consume(1);
  endtask

  initial begin
    v_in_valid = '0; v_in_last = '0; v_out_ready = '0;
    v_in_data[0] = '0; v_in_data[1] = '0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = '0; m_cnt[s] = 0; m_ovf[s] = 1'b0; m_open[s] = 0;
    end
    test_reset;
    test_basic_burst;
    test_overflow;
    test_single_beat;
    test_back_to_back;
    test_reset_mid;
    test_count_saturation;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
